k_best_sorted_store: RTL and testbench
======================================

// Module: k_best_sorted_store
// PURPOSE
// - Per-query K-best candidate store for the ANN search datapath. Holds DEPTH
//   query slots, each a list of K {dist, idx} entries sorted ascending by dist.
// - Leaf-compute units push candidates through a 2-stage read-merge-write
//   pipeline. The readout unit fetches a whole sorted list in one access.
// - A clear sequencer presets every slot to "empty" (dist = all-ones) between
//   frames.
// PARAMETERS
// - DIST_WIDTH  32               distance width (unsigned)
// - IDX_WIDTH   9                candidate patch index width
// - K           4                entries per slot (>=2)
// - DEPTH       256              number of query slots
// - ADDR_WIDTH  $clog2(DEPTH)    slot address width
// PORTS
// - clk          in   1                     clock
// - rst          in   1                     async reset, active-high
// - clear_start  in   1                     request full clear (pulse)
// - busy         out  1                     clear pending or in progress
// - clear_done   out  1                     1-cycle pulse when clear completes
// - ins_valid    in   1                     candidate valid
// - ins_ready    out  1                     store accepts candidate
// - ins_addr     in   ADDR_WIDTH            target slot
// - ins_dist     in   DIST_WIDTH            candidate distance
// - ins_idx      in   IDX_WIDTH             candidate index
// - ins_drop     out  1                     pulse: S2 candidate discarded
// - rd_en        in   1                     read request
// - rd_addr      in   ADDR_WIDTH            slot to read
// - rd_valid     out  1                     rd_dist/rd_idx valid (1 cycle)
// - rd_dist      out  [DIST_WIDTH-1:0][K]   sorted distances, [0] = best
// - rd_idx       out  [IDX_WIDTH-1:0][K]    matching indices
// BEHAVIOUR
// - Reset: state IDLE; busy, clear_done, ins_drop and rd_valid are 0;
//   rd_dist/rd_idx are 0; pipeline valids are 0. Array contents are undefined
//   until a clear completes.
// - FSM IDLE: ins_ready = !clear_start. When clear_start=1, go to CLR_WAIT.
// - FSM CLR_WAIT: ins_ready=0. Go to CLEAR once S1 and S2 are empty.
// - FSM CLEAR: counter runs 0..DEPTH-1. Each cycle writes one slot to
//   dist=all-ones, idx=0. The final write pulses clear_done and returns to IDLE.
// - busy = (state != IDLE). clear_start is ignored while busy.
// - Handshake: a candidate transfers on ins_valid && ins_ready. clear_start
//   takes priority over a same-cycle insert.
// - S1, accept cycle t: read slot ins_addr. Data is registered.
// - S2, cycle t+1: merge and write back.
//   * pos = count of entries with dist <= ins_dist (ties stay after existing
//     entries, so ordering is stable).
//   * pos == K: drop, no write, ins_drop=1.
//   * Otherwise shift entries pos..K-2 down one place, insert at pos, and
//     discard the old entry K-1.
// - Hazard: if S2 writes slot A while S1 holds slot A, S1 takes the S2 merged
//   list (forwarding). Full throughput is 1 insert/cycle, including
//   back-to-back inserts to the same slot.
// - Read port is independent of the insert path. rd_valid comes 1 cycle after
//   rd_en. The read returns the array state before any same-cycle write.
//   An insert accepted at t is visible to an rd_en issued at t+2 or later.
// - rd_en during CLEAR returns undefined data. The bench must not rely on it.
// - Async rst mid-clear or mid-insert: abort immediately, values as at reset.
// CONFIGURATION
// - KBEST_DUP_FILTER_EN defined: S2 also drops (ins_drop=1, no write) when
//   ins_idx equals the idx of any entry whose dist != all-ones.
// - Not defined: duplicate indices are stored as separate entries.
// TESTING
// - rst, clear_start -> busy for DEPTH+1..DEPTH+3 cycles, then clear_done.
//   Read slot 0 and slot DEPTH-1 -> all dist=all-ones, idx=0.
// - K=4, slot 3, spaced inserts dist/idx 40/1, 10/2, 30/3, 20/4, 50/5
//   -> rd 10,20,30,40 / 2,4,3,1. ins_drop fires for 50.
// - Same 5 candidates to slot 3 on consecutive cycles (forwarding) -> same
//   result as the spaced case. Interleave slot 4 -> slot 4 is unaffected.
// - Slot 7 holds 10/1; insert 10/9 -> rd 10,10,max,max / 1,9,0,0 (stable tie).
// - KBEST_DUP_FILTER_EN: slot 7 holds 10/1; insert 5/1 -> ins_drop=1, slot
//   unchanged. Without the macro -> rd 5,10 / 1,1.
// - Assert rst at clear cycle 100 -> busy=0 next cycle. A new clear_start
//   completes normally. Insert during CLR_WAIT -> ins_ready=0, no loss once
//   IDLE.

Source files
------------

// File: rtl/k_best_sorted_store_if.sv
// Insert, read and clear bundle for the K-best sorted store.
// master = leaf/readout/sequencer side, slave = the store.
interface k_best_sorted_store_if #(
  parameter int DIST_WIDTH = 32,
  parameter int IDX_WIDTH  = 9,
  parameter int K          = 4,
  parameter int ADDR_WIDTH = 8
);
  logic                         clear_start;
  logic                         busy;
  logic                         clear_done;
  logic                         ins_valid;
  logic                         ins_ready;
  logic [ADDR_WIDTH-1:0]        ins_addr;
  logic [DIST_WIDTH-1:0]        ins_dist;
  logic [IDX_WIDTH-1:0]         ins_idx;
  logic                         ins_drop;
  logic                         rd_en;
  logic [ADDR_WIDTH-1:0]        rd_addr;
  logic                         rd_valid;
  logic [K-1:0][DIST_WIDTH-1:0] rd_dist;
  logic [K-1:0][IDX_WIDTH-1:0]  rd_idx;

  modport master (
    output clear_start, ins_valid, ins_addr, ins_dist, ins_idx,
    output rd_en, rd_addr,
    input  busy, clear_done, ins_ready, ins_drop,
    input  rd_valid, rd_dist, rd_idx
  );

  modport slave (
    input  clear_start, ins_valid, ins_addr, ins_dist, ins_idx,
    input  rd_en, rd_addr,
    output busy, clear_done, ins_ready, ins_drop,
    output rd_valid, rd_dist, rd_idx
  );
endinterface

// File: rtl/k_best_sorted_store.sv
// Per-query K-best {dist, idx} store, lists sorted ascending by dist.
// 2-stage read-merge-write insert path with S2->S1 forwarding, a 1-cycle
// whole-list read port and a clear sequencer presetting slots to empty.
// Ports: clk, rst (async, active-high), bus (k_best_sorted_store_if.slave):
//   clear_start/busy/clear_done, ins_valid/ins_ready/ins_addr/ins_dist/
//   ins_idx/ins_drop, rd_en/rd_addr/rd_valid/rd_dist/rd_idx.
// Option: define KBEST_DUP_FILTER_EN to drop candidates whose idx already
//   sits in a non-empty entry of the target slot.
module k_best_sorted_store #(
  parameter int DIST_WIDTH = 32,
  parameter int IDX_WIDTH  = 9,
  parameter int K          = 4,
  parameter int DEPTH      = 256,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input logic              clk,
  input logic              rst,
  k_best_sorted_store_if.slave bus
);
  typedef logic [K-1:0][DIST_WIDTH-1:0] dvec_t;
  typedef logic [K-1:0][IDX_WIDTH-1:0]  ivec_t;
  typedef enum logic [1:0] {IDLE, CLR_WAIT, CLEAR} state_t;

  localparam int PW = $clog2(K+1);
  localparam logic [DIST_WIDTH-1:0] DMAX = '1;
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DEPTH-1);

  dvec_t mem_dist [DEPTH];
  ivec_t mem_idx  [DEPTH];

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  s2_valid_q, s2_valid_d;
  logic [ADDR_WIDTH-1:0] s2_addr_q, s2_addr_d;
  logic [DIST_WIDTH-1:0] s2_dist_q, s2_dist_d;
  logic [IDX_WIDTH-1:0]  s2_idx_q, s2_idx_d;
  dvec_t                 s2_ld_q, s2_ld_d;
  ivec_t                 s2_li_q, s2_li_d;
  logic                  rd_valid_q, rd_valid_d;
  dvec_t                 rd_dist_q, rd_dist_d;
  ivec_t                 rd_idx_q, rd_idx_d;

  logic                  ins_ready;
  logic                  clr_we;
  logic                  clr_done;
  logic                  accept;
  logic [PW-1:0]         pos;
  logic                  drop;
  logic                  wr_en;
  logic                  fwd;
  dvec_t                 sh_dist, m_dist;
  ivec_t                 sh_idx, m_idx;
`ifdef KBEST_DUP_FILTER_EN
  logic                  dup;
`endif

  // Clear sequencer
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ins_ready = 1'b0;
    clr_we    = 1'b0;
    clr_done  = 1'b0;
    unique case (state_q)
      IDLE: begin
        ins_ready = !bus.clear_start;
        if (bus.clear_start) state_d = CLR_WAIT;
      end
      // S1 cannot fill here, so only an in-flight S2 write must drain
      CLR_WAIT: begin
        if (!s2_valid_q) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        clr_we = 1'b1;
        cnt_d  = cnt_q + ADDR_WIDTH'(1);
        if (cnt_q == LAST) begin
          clr_done = 1'b1;
          cnt_d    = '0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // S2 merge: new entry goes after all entries with dist <= its dist
  always_comb begin
    pos = '0;
    for (int i = 0; i < K; i++) begin
      if (s2_ld_q[i] <= s2_dist_q) pos = pos + PW'(1);
    end
`ifdef KBEST_DUP_FILTER_EN
    dup = 1'b0;
    for (int i = 0; i < K; i++) begin
      if (s2_ld_q[i] != DMAX && s2_li_q[i] == s2_idx_q) dup = 1'b1;
    end
    drop = (pos == PW'(K)) || dup;
`else
    drop = (pos == PW'(K));
`endif
    sh_dist = {s2_ld_q[K-2:0], DMAX};
    sh_idx  = {s2_li_q[K-2:0], {IDX_WIDTH{1'b0}}};
    for (int i = 0; i < K; i++) begin
      if (PW'(i) < pos) begin
        m_dist[i] = s2_ld_q[i];
        m_idx[i]  = s2_li_q[i];
      end else if (PW'(i) == pos) begin
        m_dist[i] = s2_dist_q;
        m_idx[i]  = s2_idx_q;
      end else begin
        m_dist[i] = sh_dist[i];
        m_idx[i]  = sh_idx[i];
      end
    end
    wr_en = s2_valid_q && !drop;
  end

  // S1 read with forwarding of the list S2 is writing this cycle
  always_comb begin
    accept     = bus.ins_valid && ins_ready;
    fwd        = wr_en && (s2_addr_q == bus.ins_addr);
    s2_valid_d = accept;
    s2_addr_d  = s2_addr_q;
    s2_dist_d  = s2_dist_q;
    s2_idx_d   = s2_idx_q;
    s2_ld_d    = s2_ld_q;
    s2_li_d    = s2_li_q;
    if (accept) begin
      s2_addr_d = bus.ins_addr;
      s2_dist_d = bus.ins_dist;
      s2_idx_d  = bus.ins_idx;
      s2_ld_d   = fwd ? m_dist : mem_dist[bus.ins_addr];
      s2_li_d   = fwd ? m_idx : mem_idx[bus.ins_addr];
    end
  end

  // Readout port sees the array before any same-cycle write
  always_comb begin
    rd_valid_d = bus.rd_en;
    rd_dist_d  = rd_dist_q;
    rd_idx_d   = rd_idx_q;
    if (bus.rd_en) begin
      rd_dist_d = mem_dist[bus.rd_addr];
      rd_idx_d  = mem_idx[bus.rd_addr];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      s2_valid_q <= 1'b0;
      s2_addr_q  <= '0;
      s2_dist_q  <= '0;
      s2_idx_q   <= '0;
      s2_ld_q    <= '0;
      s2_li_q    <= '0;
      rd_valid_q <= 1'b0;
      rd_dist_q  <= '0;
      rd_idx_q   <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      s2_valid_q <= s2_valid_d;
      s2_addr_q  <= s2_addr_d;
      s2_dist_q  <= s2_dist_d;
      s2_idx_q   <= s2_idx_d;
      s2_ld_q    <= s2_ld_d;
      s2_li_q    <= s2_li_d;
      rd_valid_q <= rd_valid_d;
      rd_dist_q  <= rd_dist_d;
      rd_idx_q   <= rd_idx_d;
    end
  end

  // Storage array: no reset, contents are defined by the clear sequencer
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem_dist[cnt_q] <= '1;
      mem_idx[cnt_q]  <= '0;
    end else if (wr_en) begin
      mem_dist[s2_addr_q] <= m_dist;
      mem_idx[s2_addr_q]  <= m_idx;
    end
  end

  assign bus.busy       = (state_q != IDLE);
  assign bus.clear_done = clr_done;
  assign bus.ins_ready  = ins_ready;
  assign bus.ins_drop   = s2_valid_q && drop;
  assign bus.rd_valid   = rd_valid_q;
  assign bus.rd_dist    = rd_dist_q;
  assign bus.rd_idx     = rd_idx_q;
endmodule

// File: tb/tb_k_best_sorted_store.sv
// Self-checking bench for k_best_sorted_store: directed scenarios plus
// randomized inserts/reads against a queue-based sorted-list model.
module tb_k_best_sorted_store;
  localparam int DW = 32;
  localparam int IW = 9;
  localparam int K = 4;
  localparam int DEPTH = 256;
  localparam int AW = 8;
  localparam logic [DW-1:0] MAX = 32'hFFFF_FFFF;

  typedef logic [K-1:0][DW-1:0] dv_t;
  typedef logic [K-1:0][IW-1:0] iv_t;
  typedef struct {
    bit v;
    int a;
    logic [DW-1:0] d;
    logic [IW-1:0] i;
  } ins_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_vec = 0;
  int n_err = 0;

  logic [DW-1:0] md [2][8][K];
  logic [IW-1:0] mi [2][8][K];

  k_best_sorted_store_if #(
    .DIST_WIDTH(DW), .IDX_WIDTH(IW), .K(K), .ADDR_WIDTH(AW)
  ) bus ();

  k_best_sorted_store #(
    .DIST_WIDTH(DW), .IDX_WIDTH(IW), .K(K), .DEPTH(DEPTH), .ADDR_WIDTH(AW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic dv_t mk_d(logic [DW-1:0] a0, logic [DW-1:0] a1,
                               logic [DW-1:0] a2, logic [DW-1:0] a3);
    dv_t r;
    r[0] = a0; r[1] = a1; r[2] = a2; r[3] = a3;
    return r;
  endfunction

  function automatic iv_t mk_i(logic [IW-1:0] a0, logic [IW-1:0] a1,
                               logic [IW-1:0] a2, logic [IW-1:0] a3);
    iv_t r;
    r[0] = a0; r[1] = a1; r[2] = a2; r[3] = a3;
    return r;
  endfunction

  // Reference: insert into a sorted list after equal keys, keep best K
  function automatic bit model_ins(int m, int a, logic [DW-1:0] d,
                                   logic [IW-1:0] ix);
    logic [DW-1:0] qd[$];
    logic [IW-1:0] qi[$];
    int p;
`ifdef KBEST_DUP_FILTER_EN
    for (int k = 0; k < K; k++)
      if (md[m][a][k] != MAX && mi[m][a][k] == ix) return 1'b1;
`endif
    for (int k = 0; k < K; k++) begin
      qd.push_back(md[m][a][k]);
      qi.push_back(mi[m][a][k]);
    end
    p = 0;
    while (p < K && qd[p] <= d) p++;
    if (p == K) return 1'b1;
    qd.insert(p, d);
    qi.insert(p, ix);
    for (int k = 0; k < K; k++) begin
      md[m][a][k] = qd[k];
      mi[m][a][k] = qi[k];
    end
    return 1'b0;
  endfunction

  task automatic idle_inputs();
    bus.clear_start = 1'b0;
    bus.ins_valid = 1'b0;
    bus.ins_addr = '0;
    bus.ins_dist = '0;
    bus.ins_idx = '0;
    bus.rd_en = 1'b0;
    bus.rd_addr = '0;
  endtask

  task automatic run_clear(output int n, output bit done);
    n = 0;
    done = 1'b0;
    bus.clear_start = 1'b1;
    @(negedge clk);
    bus.clear_start = 1'b0;
    while (bus.busy && n < DEPTH + 10) begin
      if (bus.clear_done) done = 1'b1;
      n++;
      @(negedge clk);
    end
  endtask

  // Drives one accepted insert; returns at the cycle its merge runs
  task automatic do_ins(int a, logic [DW-1:0] d, logic [IW-1:0] i);
    bus.ins_valid = 1'b1;
    bus.ins_addr = AW'(a);
    bus.ins_dist = d;
    bus.ins_idx = i;
    @(negedge clk);
    bus.ins_valid = 1'b0;
  endtask

  // Returns at the cycle rd_valid is expected
  task automatic do_rd(int a);
    bus.rd_en = 1'b1;
    bus.rd_addr = AW'(a);
    @(negedge clk);
    bus.rd_en = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_vec++;
    if (bus.busy !== 1'b0) begin
      n_err++; $display("FAIL reset_busy got %b want 0", bus.busy);
    end
    n_vec++;
    if (bus.clear_done !== 1'b0) begin
      n_err++; $display("FAIL reset_clear_done got %b want 0", bus.clear_done);
    end
    n_vec++;
    if (bus.ins_drop !== 1'b0) begin
      n_err++; $display("FAIL reset_ins_drop got %b want 0", bus.ins_drop);
    end
    n_vec++;
    if (bus.rd_valid !== 1'b0) begin
      n_err++; $display("FAIL reset_rd_valid got %b want 0", bus.rd_valid);
    end
    n_vec++;
    if (bus.rd_dist !== '0 || bus.rd_idx !== '0) begin
      n_err++;
      $display("FAIL reset_rd_data got %h/%h want 0/0", bus.rd_dist, bus.rd_idx);
    end
    n_vec++;
    if (bus.ins_ready !== 1'b1) begin
      n_err++; $display("FAIL reset_ins_ready got %b want 1", bus.ins_ready);
    end
  endtask

  task automatic test_clear();
    int n;
    bit done;
    bus.clear_start = 1'b1;
    #1;
    n_vec++;
    if (bus.ins_ready !== 1'b0) begin
      n_err++; $display("FAIL clear_prio_ready got %b want 0", bus.ins_ready);
    end
    @(negedge clk);
    bus.clear_start = 1'b0;
    n = 0;
    done = 1'b0;
    while (bus.busy && n < DEPTH + 10) begin
      if (bus.clear_done) done = 1'b1;
      n++;
      @(negedge clk);
    end
    n_vec++;
    if (n < DEPTH + 1 || n > DEPTH + 3 || !done) begin
      n_err++;
      $display("FAIL clear_len got %0d cycles done=%b want %0d..%0d done=1",
               n, done, DEPTH + 1, DEPTH + 3);
    end
    do_rd(0);
    n_vec++;
    if (bus.rd_valid !== 1'b1 || bus.rd_dist !== mk_d(MAX, MAX, MAX, MAX) ||
        bus.rd_idx !== '0) begin
      n_err++;
      $display("FAIL clear_slot0 got v=%b %h/%h want all-ones/0",
               bus.rd_valid, bus.rd_dist, bus.rd_idx);
    end
    do_rd(DEPTH - 1);
    n_vec++;
    if (bus.rd_valid !== 1'b1 || bus.rd_dist !== mk_d(MAX, MAX, MAX, MAX) ||
        bus.rd_idx !== '0) begin
      n_err++;
      $display("FAIL clear_slot_last got v=%b %h/%h want all-ones/0",
               bus.rd_valid, bus.rd_dist, bus.rd_idx);
    end
  endtask

  task automatic test_spaced();
    logic [DW-1:0] td [5] = '{40, 10, 30, 20, 50};
    logic [IW-1:0] ti [5] = '{1, 2, 3, 4, 5};
    logic drops [5];
    for (int j = 0; j < 5; j++) begin
      do_ins(3, td[j], ti[j]);
      drops[j] = bus.ins_drop;
      repeat (2) @(negedge clk);
    end
    n_vec++;
    if (drops[4] !== 1'b1) begin
      n_err++; $display("FAIL spaced_drop50 got %b want 1", drops[4]);
    end
    n_vec++;
    if (drops[3] !== 1'b0) begin
      n_err++; $display("FAIL spaced_nodrop20 got %b want 0", drops[3]);
    end
    do_rd(3);
    n_vec++;
    if (bus.rd_dist !== mk_d(10, 20, 30, 40) ||
        bus.rd_idx !== mk_i(2, 4, 3, 1)) begin
      n_err++;
      $display("FAIL spaced_slot3 got %h/%h want 10,20,30,40/2,4,3,1",
               bus.rd_dist, bus.rd_idx);
    end
  endtask

  task automatic test_back_to_back();
    int ta [7] = '{3, 4, 3, 3, 4, 3, 3};
    logic [DW-1:0] td [7] = '{40, 7, 10, 30, 8, 20, 50};
    logic [IW-1:0] ti [7] = '{1, 11, 2, 3, 12, 4, 5};
    logic drops [7];
    int n;
    bit done;
    run_clear(n, done);
    n_vec++;
    if (!done || bus.busy) begin
      n_err++; $display("FAIL b2b_clear got done=%b busy=%b want 1/0", done, bus.busy);
    end
    for (int j = 0; j <= 7; j++) begin
      if (j > 0) drops[j-1] = bus.ins_drop;
      if (j < 7) begin
        bus.ins_valid = 1'b1;
        bus.ins_addr = AW'(ta[j]);
        bus.ins_dist = td[j];
        bus.ins_idx = ti[j];
      end else begin
        bus.ins_valid = 1'b0;
      end
      @(negedge clk);
    end
    n_vec++;
    if ({drops[0], drops[1], drops[2], drops[3], drops[4], drops[5], drops[6]}
        !== 7'b0000001) begin
      n_err++;
      $display("FAIL b2b_drops got %b%b%b%b%b%b%b want 0000001", drops[0],
               drops[1], drops[2], drops[3], drops[4], drops[5], drops[6]);
    end
    do_rd(3);
    n_vec++;
    if (bus.rd_dist !== mk_d(10, 20, 30, 40) ||
        bus.rd_idx !== mk_i(2, 4, 3, 1)) begin
      n_err++;
      $display("FAIL b2b_slot3 got %h/%h want 10,20,30,40/2,4,3,1",
               bus.rd_dist, bus.rd_idx);
    end
    do_rd(4);
    n_vec++;
    if (bus.rd_dist !== mk_d(7, 8, MAX, MAX) ||
        bus.rd_idx !== mk_i(11, 12, 0, 0)) begin
      n_err++;
      $display("FAIL b2b_slot4 got %h/%h want 7,8,max,max/11,12,0,0",
               bus.rd_dist, bus.rd_idx);
    end
  endtask

  task automatic test_tie_dup();
    logic drop_tie;
    logic drop_dup;
    do_ins(7, 10, 1);
    do_ins(7, 10, 9);
    drop_tie = bus.ins_drop;
    do_ins(6, 10, 1);
    do_ins(6, 5, 1);
    drop_dup = bus.ins_drop;
    repeat (2) @(negedge clk);
    n_vec++;
    if (drop_tie !== 1'b0) begin
      n_err++; $display("FAIL tie_drop got %b want 0", drop_tie);
    end
    do_rd(7);
    n_vec++;
    if (bus.rd_dist !== mk_d(10, 10, MAX, MAX) ||
        bus.rd_idx !== mk_i(1, 9, 0, 0)) begin
      n_err++;
      $display("FAIL tie_slot7 got %h/%h want 10,10,max,max/1,9,0,0",
               bus.rd_dist, bus.rd_idx);
    end
    do_rd(6);
`ifdef KBEST_DUP_FILTER_EN
    n_vec++;
    if (drop_dup !== 1'b1) begin
      n_err++; $display("FAIL dup_drop got %b want 1", drop_dup);
    end
    n_vec++;
    if (bus.rd_dist !== mk_d(10, MAX, MAX, MAX) ||
        bus.rd_idx !== mk_i(1, 0, 0, 0)) begin
      n_err++;
      $display("FAIL dup_slot6 got %h/%h want 10,max,max,max/1,0,0,0",
               bus.rd_dist, bus.rd_idx);
    end
`else
    n_vec++;
    if (drop_dup !== 1'b0) begin
      n_err++; $display("FAIL dup_drop got %b want 0", drop_dup);
    end
    n_vec++;
    if (bus.rd_dist !== mk_d(5, 10, MAX, MAX) ||
        bus.rd_idx !== mk_i(1, 1, 0, 0)) begin
      n_err++;
      $display("FAIL dup_slot6 got %h/%h want 5,10,max,max/1,1,0,0",
               bus.rd_dist, bus.rd_idx);
    end
`endif
  endtask

  task automatic test_random();
    ins_t acc_a, acc_b;
    bit rd_pend;
    bit exp_drop;
    dv_t exp_d;
    iv_t exp_i;
    int ra;
    int n;
    bit done;
    run_clear(n, done);
    n_vec++;
    if (!done || bus.busy) begin
      n_err++; $display("FAIL rnd_clear got done=%b busy=%b want 1/0", done, bus.busy);
    end
    for (int m = 0; m < 2; m++)
      for (int a = 0; a < 8; a++)
        for (int k = 0; k < K; k++) begin
          md[m][a][k] = MAX;
          mi[m][a][k] = '0;
        end
    acc_a = '{0, 0, 0, 0};
    acc_b = '{0, 0, 0, 0};
    rd_pend = 1'b0;
    exp_drop = 1'b0;
    for (int c = 0; c <= 400; c++) begin
      if (c > 0) begin
        n_vec++;
        if (bus.ins_drop !== exp_drop) begin
          n_err++;
          $display("FAIL rnd_drop cyc %0d got %b want %b", c, bus.ins_drop, exp_drop);
        end
        if (rd_pend) begin
          n_vec++;
          if (bus.rd_valid !== 1'b1 || bus.rd_dist !== exp_d ||
              bus.rd_idx !== exp_i) begin
            n_err++;
            $display("FAIL rnd_read cyc %0d got v=%b %h/%h want %h/%h", c,
                     bus.rd_valid, bus.rd_dist, bus.rd_idx, exp_d, exp_i);
          end
        end
      end
      // Reads see inserts accepted two or more cycles earlier
      if (acc_b.v) void'(model_ins(1, acc_b.a, acc_b.d, acc_b.i));
      acc_b = acc_a;
      if (c == 400) begin
        idle_inputs();
        break;
      end
      rd_pend = ($urandom_range(0, 2) == 0);
      ra = $urandom_range(0, 7);
      bus.rd_en = rd_pend;
      bus.rd_addr = AW'(ra);
      for (int k = 0; k < K; k++) begin
        exp_d[k] = md[1][ra][k];
        exp_i[k] = mi[1][ra][k];
      end
      acc_a.v = ($urandom_range(0, 3) != 0);
      acc_a.a = $urandom_range(0, 7);
      acc_a.d = DW'($urandom_range(0, 63));
      acc_a.i = IW'($urandom_range(0, 15));
      bus.ins_valid = acc_a.v;
      bus.ins_addr = AW'(acc_a.a);
      bus.ins_dist = acc_a.d;
      bus.ins_idx = acc_a.i;
      exp_drop = acc_a.v ? model_ins(0, acc_a.a, acc_a.d, acc_a.i) : 1'b0;
      #1;
      if (acc_a.v) begin
        n_vec++;
        if (bus.ins_ready !== 1'b1) begin
          n_err++; $display("FAIL rnd_ready cyc %0d got %b want 1", c, bus.ins_ready);
        end
      end
      @(negedge clk);
    end
    @(negedge clk);
  endtask

  task automatic test_rst_mid_clear();
    int n;
    bit done;
    bus.clear_start = 1'b1;
    @(negedge clk);
    bus.clear_start = 1'b0;
    repeat (101) @(negedge clk);
    n_vec++;
    if (bus.busy !== 1'b1) begin
      n_err++; $display("FAIL midclr_busy_before got %b want 1", bus.busy);
    end
    rst = 1'b1;
    #1;
    n_vec++;
    if (bus.busy !== 1'b0 || bus.clear_done !== 1'b0 || bus.rd_valid !== 1'b0) begin
      n_err++;
      $display("FAIL midclr_abort got busy=%b done=%b rdv=%b want 0/0/0",
               bus.busy, bus.clear_done, bus.rd_valid);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    bus.clear_start = 1'b1;
    @(negedge clk);
    bus.clear_start = 1'b0;
    bus.ins_valid = 1'b1;
    bus.ins_addr = AW'(9);
    bus.ins_dist = 77;
    bus.ins_idx = 3;
    #1;
    n_vec++;
    if (bus.ins_ready !== 1'b0) begin
      n_err++; $display("FAIL clrwait_ready got %b want 0", bus.ins_ready);
    end
    n = 0;
    done = 1'b0;
    while (!bus.ins_ready && n < DEPTH + 20) begin
      if (bus.clear_done) done = 1'b1;
      n++;
      @(negedge clk);
    end
    n_vec++;
    if (!bus.ins_ready || !done) begin
      n_err++;
      $display("FAIL reclear_done got ready=%b done=%b after %0d want 1/1",
               bus.ins_ready, done, n);
    end
    @(negedge clk);
    bus.ins_valid = 1'b0;
    repeat (2) @(negedge clk);
    do_rd(9);
    n_vec++;
    if (bus.rd_dist !== mk_d(77, MAX, MAX, MAX) ||
        bus.rd_idx !== mk_i(3, 0, 0, 0)) begin
      n_err++;
      $display("FAIL held_insert got %h/%h want 77,max,max,max/3,0,0,0",
               bus.rd_dist, bus.rd_idx);
    end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_clear();
    test_spaced();
    test_back_to_back();
    test_tie_dup();
    test_random();
    test_rst_mid_clear();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
